dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 62 ++++++
 tb/tb_dmem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the MEM stage and an external loader/debug port, with starvation-bounded ext grants.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        p_memread,
  input  logic        p_memwrite,
  input  logic [31:0] p_addr,
  input  logic [31:0] p_wdata,
  output logic [31:0] p_rdata,
  output logic        stall,
  input  logic        x_req,
  input  logic        x_we,
  input  logic [31:0] x_addr,
  input  logic [31:0] x_wdata,
  output logic        x_ack,
  output logic [31:0] x_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_memread,
  output logic        mem_memwrite,
  input  logic [31:0] mem_rdata
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXT  = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;
  localparam logic [2:0] LIM  = 3'(STARVE_LIMIT);
  logic [1:0]  r_state;
  logic [2:0]  r_starve;
  logic [31:0] r_x_rdata;
  logic        w_p_act;
  logic        w_ext;
  logic        w_grant;
  always_comb begin
    w_p_act      = p_memread | p_memwrite;
    w_ext        = r_state == EXT;
    w_grant      = r_state == IDLE && x_req && (!w_p_act || r_starve == LIM);
    mem_addr     = w_ext ? x_addr : p_addr;
    mem_wdata    = w_ext ? x_wdata : p_wdata;
    // strobes are gated by reset so an access abandoned by reset never commits
    mem_memwrite = !reset && (w_ext ? x_we : p_memwrite);
    mem_memread  = !reset && (w_ext ? !x_we : p_memread);
    stall        = w_ext && w_p_act;
    p_rdata      = w_ext ? 32'd0 : mem_rdata;
    x_ack        = r_state == ACK;
    x_rdata      = r_x_rdata;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_starve  <= 3'd0;
      r_x_rdata <= 32'd0;
    end else begin
      r_state <= w_grant ? EXT : w_ext ? ACK : IDLE;
      if (r_state == IDLE)
        r_starve <= (w_grant || !x_req) ? 3'd0 : (r_starve == LIM ? LIM : r_starve + 3'd1);
      if (w_ext && !x_we)
        r_x_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus with a transaction-level reference model and memory, checked every cycle.
module tb_dmem_arbiter;
  localparam int LIM = 4;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        p_memread = 1'b0, p_memwrite = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0, p_rdata;
  logic        stall;
  logic        x_req = 1'b0, x_we = 1'b0;
  logic [31:0] x_addr = '0, x_wdata = '0;
  logic        x_ack;
  logic [31:0] x_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_memread, mem_memwrite;
  logic [31:0] env_mem [256];
  logic [31:0] m_mem [256];
  int          checks = 0, failures = 0, stall_cycles = 0;
  bit          chk_en = 1'b0;
  int          m_phase = 0, m_wait = 0;
  logic [31:0] m_xr = '0;
  logic        m_busy, e_wr, e_rd, e_stall, e_ack;
  logic [31:0] e_addr, e_wdata, e_prd;

  dmem_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clock(clock), .reset(reset),
    .p_memread(p_memread), .p_memwrite(p_memwrite), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_rdata(p_rdata), .stall(stall),
    .x_req(x_req), .x_we(x_we), .x_addr(x_addr), .x_wdata(x_wdata),
    .x_ack(x_ack), .x_rdata(x_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  assign mem_rdata = env_mem[mem_addr[7:0]];
  always @(posedge clock) if (mem_memwrite) env_mem[mem_addr[7:0]] <= mem_wdata;

  // reference: phase 0 = free, 1 = ext access in progress, 2 = completion cycle
  assign m_busy  = m_phase == 1;
  assign e_addr  = m_busy ? x_addr : p_addr;
  assign e_wdata = m_busy ? x_wdata : p_wdata;
  assign e_wr    = !reset && (m_busy ? x_we : p_memwrite);
  assign e_rd    = !reset && (m_busy ? !x_we : p_memread);
  assign e_stall = m_busy && (p_memread || p_memwrite);
  assign e_prd   = m_busy ? 32'd0 : m_mem[p_addr[7:0]];
  assign e_ack   = m_phase == 2;

  always @(posedge clock) begin
    chk_en <= 1'b1;
    if (reset) begin
      m_phase <= 0;
      m_wait  <= 0;
      m_xr    <= '0;
    end else begin
      if (e_wr) m_mem[e_addr[7:0]] <= e_wdata;
      if (m_phase == 0) begin
        if (x_req && (!(p_memread || p_memwrite) || m_wait == LIM)) begin
          m_phase <= 1;
          m_wait  <= 0;
        end else
          m_wait <= x_req ? (m_wait < LIM ? m_wait + 1 : LIM) : 0;
      end else if (m_phase == 1) begin
        m_phase <= 2;
        if (!x_we) m_xr <= m_mem[x_addr[7:0]];
      end else
        m_phase <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("c_mem_addr", mem_addr, e_addr);
      chk("c_mem_wdata", mem_wdata, e_wdata);
      chk("c_mem_memwrite", 32'(mem_memwrite), 32'(e_wr));
      chk("c_mem_memread", 32'(mem_memread), 32'(e_rd));
      chk("c_stall", 32'(stall), 32'(e_stall));
      chk("c_p_rdata", p_rdata, e_prd);
      chk("c_x_ack", 32'(x_ack), 32'(e_ack));
      chk("c_x_rdata", x_rdata, m_xr);
      if (stall) stall_cycles++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic we, input logic [31:0] a, input logic [31:0] d, output int n);
    x_req = 1'b1; x_we = we; x_addr = a; x_wdata = d;
    n = 0;
    while (!x_ack && n < 20) begin
      tick();
      n++;
    end
    x_req = 1'b0;
    tick();
  endtask

  initial begin
    int n, s0;
    logic [4:0] pat;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = '0;
      m_mem[i]   = '0;
    end
    env_mem[7] = 32'd7;        m_mem[7] = 32'd7;
    env_mem[9] = 32'h1234;     m_mem[9] = 32'h1234;
    p_memwrite = 1'b1; p_addr = 32'd9; p_wdata = 32'hdead;
    tick(); tick();
    chk("rst_wr_blocked", 32'(mem_memwrite), 32'd0);
    chk("rst_x_ack", 32'(x_ack), 32'd0);
    chk("rst_x_rdata", x_rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_no_write", env_mem[9], 32'h1234);
    reset = 1'b0;
    #1;
    chk("post_rst_wr", 32'(mem_memwrite), 32'd1);
    chk("post_rst_addr", mem_addr, 32'd9);
    tick();
    p_memwrite = 1'b0;
    chk("pipe_write", env_mem[9], 32'hdead);
    // idle-pipe ext read
    x_req = 1'b1; x_we = 1'b0; x_addr = 32'd7;
    tick();
    chk("ext_rd_strobe", 32'(mem_memread), 32'd1);
    chk("ext_rd_addr", mem_addr, 32'd7);
    chk("ext_ack_low", 32'(x_ack), 32'd0);
    tick();
    chk("ext_rd_ack", 32'(x_ack), 32'd1);
    chk("ext_rd_data", x_rdata, 32'd7);
    x_req = 1'b0;
    tick();
    chk("ack_one_cycle", 32'(x_ack), 32'd0);
    // idle-pipe ext write then pipeline read-back
    req(1'b1, 32'd20, 32'hA5, n);
    chk("wr_latency", 32'(n), 32'd2);
    chk("wr_keeps_xrdata", x_rdata, 32'd7);
    p_memread = 1'b1; p_addr = 32'd20;
    #1;
    chk("wr_readback", p_rdata, 32'hA5);
    // busy pipeline: forced grant after LIM denied cycles
    s0 = stall_cycles;
    req(1'b0, 32'd9, 32'd0, n);
    chk("forced_latency", 32'(n), 32'd6);
    chk("forced_xrdata", x_rdata, 32'hdead);
    chk("forced_stall_len", 32'(stall_cycles - s0), 32'd1);
    s0 = stall_cycles;
    req(1'b0, 32'd7, 32'd0, n);
    chk("starve_cleared", 32'(n), 32'd6);
    chk("forced_stall_len2", 32'(stall_cycles - s0), 32'd1);
    p_memread = 1'b0;
    // pipeline write wins over a simultaneous ext request
    p_memwrite = 1'b1; p_addr = 32'd3; p_wdata = 32'd9;
    x_req = 1'b1; x_we = 1'b0; x_addr = 32'd3;
    tick();
    p_memwrite = 1'b0;
    n = 1;
    while (!x_ack && n < 20) begin
      tick();
      n++;
    end
    chk("pipe_first_latency", 32'(n), 32'd3);
    chk("pipe_first_xrdata", x_rdata, 32'd9);
    chk("pipe_first_mem", env_mem[3], 32'd9);
    x_req = 1'b0;
    tick();
    // reset during an ext write abandons it
    x_req = 1'b1; x_we = 1'b1; x_addr = 32'd5; x_wdata = 32'h55;
    tick();
    chk("ext_wr_strobe", 32'(mem_memwrite), 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_in_ext_wr", 32'(mem_memwrite), 32'd0);
    tick();
    reset = 1'b0; x_req = 1'b0;
    #1;
    chk("abandon_mem", env_mem[5], 32'd0);
    chk("abandon_ack", 32'(x_ack), 32'd0);
    chk("abandon_stall", 32'(stall), 32'd0);
    chk("abandon_xrdata", x_rdata, 32'd0);
    tick();
    chk("abandon_ack2", 32'(x_ack), 32'd0);
    // x_req held through ACK: next grant only from the following IDLE cycle
    x_req = 1'b1; x_we = 1'b0; x_addr = 32'd7;
    pat = '0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      pat[k-1] = x_ack;
    end
    x_req = 1'b0;
    tick();
    chk("held_req_acks", 32'(pat), 32'b10010);
    chk("held_req_data", x_rdata, 32'd7);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
